// File: rtl/uart_rx_deframer_pkg.sv
// uart_rx_deframer_pkg: shared state encoding, majority sample points and voter for the UART receiver
package uart_rx_deframer_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
   localparam logic [3:0] SMP_A   = 4'd7;
   localparam logic [3:0] SMP_B   = 4'd8;
   localparam logic [3:0] SMP_C   = 4'd9;
   localparam logic [3:0] SC_LAST = 4'd15;
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction
endpackage

// File: rtl/uart_os_tick.sv
// uart_os_tick: oversample divider producing one tick every DIV clocks, restartable by clear
module uart_os_tick #(
   parameter int DIV_W = 16,
   parameter int DIV   = 13
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);
   localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);
   logic [DIV_W-1:0] cnt;
   assign tick = ~clear & (cnt == LAST);
   // free-running modulo-DIV counter, held at zero while clear is high
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else     cnt <= (clear | (cnt == LAST)) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1 UART receiver with 16x oversampling, majority vote, framing and break detection
module uart_rx_deframer
   import uart_rx_deframer_pkg::*;
#(
   parameter int DIV_W = 16,
   parameter int DIV   = 13
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_strobe,
   output logic       rx_frame_err,
   output logic       rx_break,
   output logic       rx_busy
);
   rx_state_t  state, state_n;
   logic       s1, s2, s3, rxs, fall;
   logic       tick, sc_clr, smp_a, smp_b, dec, bit_val, high_done;
   logic       v_a, v_b, load, shift_en, ferr;
   logic [3:0] sc, sc_nx;
   logic [2:0] idx;
   logic [7:0] shift;

   assign rxs       = s2;
   assign fall      = s3 & ~s2;
   assign sc_nx     = sc + 4'd1;
   assign smp_a     = tick & (sc_nx == SMP_A);
   assign smp_b     = tick & (sc_nx == SMP_B);
   assign dec       = tick & (sc_nx == SMP_C);
   assign bit_val   = maj3(v_a, v_b, rxs);
   assign high_done = tick & (sc == SC_LAST) & rxs;
   assign sc_clr    = (state == IDLE) | ((state == WAIT_HIGH) & ~rxs) | ((state == STOP) & dec);
   assign rx_busy   = state != IDLE;

   uart_os_tick #(.DIV_W(DIV_W), .DIV(DIV)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (state == IDLE),
      .tick  (tick)
   );

   // two-flop synchronizer plus a third flop for falling-edge detection
   always_ff @(posedge clk or posedge rst)
      if (rst) {s1, s2, s3} <= 3'b111;
      else     {s1, s2, s3} <= {rx_in, s1, s2};

   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_n;

   // next-state and per-cycle control decisions
   always_comb begin
      state_n  = state;
      load     = 1'b0;
      shift_en = 1'b0;
      ferr     = 1'b0;
      case (state)
         IDLE:      if (fall) state_n = START;
         START:     if (dec) state_n = bit_val ? IDLE : DATA;
         DATA:      if (dec) begin
                       shift_en = 1'b1;
                       if (idx == 3'd7) state_n = STOP;
                    end
         STOP:      if (dec) begin
                       load    = bit_val;
                       ferr    = ~bit_val;
                       state_n = bit_val ? IDLE : WAIT_HIGH;
                    end
         WAIT_HIGH: if (high_done) state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   // sample counter, vote capture, shift register and registered status pulses
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sc           <= '0;
         v_a          <= 1'b1;
         v_b          <= 1'b1;
         idx          <= '0;
         shift        <= '0;
         rx_data      <= '0;
         rx_strobe    <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_break     <= 1'b0;
      end else begin
         sc           <= sc_clr ? 4'd0 : tick ? sc_nx : sc;
         v_a          <= smp_a ? rxs : v_a;
         v_b          <= smp_b ? rxs : v_b;
         idx          <= (state == START) ? 3'd0 : shift_en ? idx + 3'd1 : idx;
         shift        <= shift_en ? {bit_val, shift[7:1]} : shift;
         rx_data      <= load ? shift : rx_data;
         rx_strobe    <= load;
         rx_frame_err <= ferr;
         rx_break     <= ferr & (shift == 8'h00);
      end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed scoreboard bench for the UART receiver at DIV=4 (64 clk per bit)
module tb_uart_rx_deframer;
   localparam int DIV = 4;
   localparam int BP  = 64;
   localparam int LAT_MAX = 9*BP + 9*DIV + 3 + DIV;
   localparam int LAT_MIN = 9*BP + 9*DIV + 3 - DIV;

   logic       clk = 1'b0, rst = 1'b1, rx_in = 1'b1;
   logic [7:0] rx_data;
   logic       rx_strobe, rx_frame_err, rx_break, rx_busy;
   int         errors = 0, checks = 0;
   int         cyc = 0, strobe_cyc = 0, start_cyc = 0, n_ferr = 0, n_brk = 0;
   int         f0, b0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   uart_rx_deframer #(.DIV_W(16), .DIV(DIV)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_in        (rx_in),
      .rx_data      (rx_data),
      .rx_strobe    (rx_strobe),
      .rx_frame_err (rx_frame_err),
      .rx_break     (rx_break),
      .rx_busy      (rx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_strobe) begin
         got_q.push_back(rx_data);
         strobe_cyc <= cyc;
      end
      if (rx_frame_err) n_ferr <= n_ferr + 1;
      if (rx_break) n_brk <= n_brk + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tx_bit(input logic b, input int bp);
      rx_in = b;
      repeat (bp) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic stop, input int bp);
      if (stop) exp_q.push_back(d);
      start_cyc = cyc;
      tx_bit(1'b0, bp);
      for (int i = 0; i < 8; i++) tx_bit(d[i], bp);
      tx_bit(stop, bp);
   endtask

   task automatic expect_rx(input string tag);
      chk({tag, "_avail"}, 32'(got_q.size() > 0), 32'd1);
      if (got_q.size() > 0 && exp_q.size() > 0) chk(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #22;
      chk("rst_data", 32'(rx_data), 32'h00);
      chk("rst_strobe", 32'(rx_strobe), 32'd0);
      chk("rst_ferr", 32'(rx_frame_err), 32'd0);
      chk("rst_brk", 32'(rx_break), 32'd0);
      chk("rst_busy", 32'(rx_busy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2*BP);

      f0 = n_ferr; b0 = n_brk;
      send(8'h55, 1'b1, BP);
      idle(BP);
      expect_rx("t1_data");
      chk("t1_lat_max", 32'(strobe_cyc - start_cyc <= LAT_MAX), 32'd1);
      chk("t1_lat_min", 32'(strobe_cyc - start_cyc >= LAT_MIN), 32'd1);
      chk("t1_noerr", 32'(n_ferr - f0 + n_brk - b0), 32'd0);

      rx_in = 1'b0;
      repeat (8) @(posedge clk); #1;
      chk("t2_busy_hi", 32'(rx_busy), 32'd1);
      repeat (8) @(posedge clk); #1;
      rx_in = 1'b1;
      repeat (BP - 16) @(posedge clk); #1;
      chk("t2_busy_lo", 32'(rx_busy), 32'd0);
      chk("t2_nostrobe", 32'(got_q.size()), 32'd0);
      chk("t2_noerr", 32'(n_ferr - f0), 32'd0);
      send(8'hC3, 1'b1, BP);
      idle(BP);
      expect_rx("t2_data");

      f0 = n_ferr; b0 = n_brk;
      send(8'hA3, 1'b0, BP);
      tx_bit(1'b0, BP);
      idle(3*BP);
      chk("t3_ferr", 32'(n_ferr - f0), 32'd1);
      chk("t3_nobrk", 32'(n_brk - b0), 32'd0);
      chk("t3_nostrobe", 32'(got_q.size()), 32'd0);
      chk("t3_hold", 32'(rx_data), 32'hC3);
      send(8'h3C, 1'b1, BP);
      idle(BP);
      expect_rx("t3_data");

      f0 = n_ferr; b0 = n_brk;
      tx_bit(1'b0, 12*BP);
      rx_in = 1'b1;
      repeat (32) @(posedge clk); #1;
      chk("t4_busy_wait", 32'(rx_busy), 32'd1);
      repeat (64) @(posedge clk); #1;
      chk("t4_busy_idle", 32'(rx_busy), 32'd0);
      chk("t4_ferr", 32'(n_ferr - f0), 32'd1);
      chk("t4_brk", 32'(n_brk - b0), 32'd1);
      chk("t4_nostrobe", 32'(got_q.size()), 32'd0);
      send(8'h0F, 1'b1, BP);
      idle(BP);
      expect_rx("t4_data");

      f0 = n_ferr;
      send(8'h00, 1'b1, 66);
      send(8'hFF, 1'b1, 66);
      send(8'h80, 1'b1, 66);
      send(8'h00, 1'b1, 62);
      send(8'hFF, 1'b1, 62);
      send(8'h80, 1'b1, 62);
      idle(BP);
      for (int i = 0; i < 6; i++) expect_rx("t5_data");
      chk("t5_noerr", 32'(n_ferr - f0), 32'd0);

      tx_bit(1'b0, BP);
      for (int i = 0; i < 4; i++) tx_bit(i[0] ? 1'b1 : 1'b0, BP);
      rx_in = 1'b1;
      repeat (32) @(posedge clk); #1;
      rx_in = 1'b1;
      rst = 1'b1;
      #1;
      chk("t6_rst_data", 32'(rx_data), 32'h00);
      chk("t6_rst_busy", 32'(rx_busy), 32'd0);
      chk("t6_rst_strobe", 32'(rx_strobe), 32'd0);
      repeat (4) @(posedge clk); #1;
      rst = 1'b0;
      idle(12*BP);
      chk("t6_nostrobe", 32'(got_q.size()), 32'd0);
      send(8'h69, 1'b1, BP);
      idle(BP);
      expect_rx("t6_data");
      chk("end_busy", 32'(rx_busy), 32'd0);
      chk("end_q", 32'(got_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
